// File: rtl/icache_line_fill_ctrl_if.sv
// icache_line_fill_ctrl_if: Wishbone burst read bus between the fill controller and application memory.
interface icache_line_fill_ctrl_if #(
  parameter int WB_AW = 32,
  parameter int WB_DW = 32,
  parameter int BLW = 10
);
  logic wb_app_stb_o;
  logic [WB_AW-1:0] wb_app_adr_o;
  logic wb_app_we_o;
  logic [WB_DW-1:0] wb_app_dat_o;
  logic [3:0] wb_app_sel_o;
  logic [BLW-1:0] wb_app_bl_o;
  logic [WB_DW-1:0] wb_app_dat_i;
  logic wb_app_ack_i;
  logic wb_app_lack_i;
  logic wb_app_err_i;
  modport master (
    output wb_app_stb_o, wb_app_adr_o, wb_app_we_o, wb_app_dat_o, wb_app_sel_o, wb_app_bl_o,
    input wb_app_dat_i, wb_app_ack_i, wb_app_lack_i, wb_app_err_i
  );
  modport slave (
    input wb_app_stb_o, wb_app_adr_o, wb_app_we_o, wb_app_dat_o, wb_app_sel_o, wb_app_bl_o,
    output wb_app_dat_i, wb_app_ack_i, wb_app_lack_i, wb_app_err_i
  );
endinterface

// File: rtl/icache_line_fill_ctrl.sv
// icache_line_fill_ctrl: I-cache line refill/prefill over Wishbone bursts with early restart and bus-error abort.
// Optional ICACHE_CRITICAL_WORD_FIRST_EN splits a refill into a critical-word burst plus a wrap burst.
module icache_line_fill_ctrl #(
  parameter int WB_AW = 32,
  parameter int WB_DW = 32,
  parameter int CACHELINES = 16,
  parameter int CACHESIZE = 32,
  localparam int LNW = $clog2(CACHELINES),
  localparam int LW = $clog2(CACHESIZE),
  localparam int MAW = LNW + LW,
  localparam int TAG_WD = WB_AW - LW - 2,
  localparam int BLW = MAW + 1
) (
  input  logic mclk,
  input  logic rst_n,
  input  logic [WB_AW-1:0] cpu_addr,
  output logic [WB_DW-1:0] wb_cpu_dat_o,
  output logic wb_cpu_ack_o,
  output logic wb_cpu_err_o,
  icache_line_fill_ctrl_if.master app,
  input  logic [LNW-1:0] tag_cur_loc,
  output logic tag_uwr,
  output logic [LNW-1:0] tag_uptr,
  output logic tag_wr,
  output logic [LNW-1:0] tag_wptr,
  output logic [TAG_WD:0] tag_wdata,
  output logic cache_mem_clk0,
  output logic cache_mem_csb0,
  output logic cache_mem_web0,
  output logic [MAW-1:0] cache_mem_addr0,
  output logic [3:0] cache_mem_wmask0,
  output logic [WB_DW-1:0] cache_mem_din0,
  input  logic cache_refill_req,
  input  logic cache_prefill_req,
  input  logic [WB_AW-1:0] prefill_base,
  input  logic [LNW-1:0] prefill_lines,
  output logic cache_busy,
  output logic fill_done,
  output logic fill_err
);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  typedef enum logic [2:0] {IDLE, REFILL, REFILL_WRAP, PREFILL, DONE} state_t;
  logic second;
`else
  typedef enum logic [2:0] {IDLE, REFILL, PREFILL, DONE} state_t;
`endif
  state_t state;
  logic stb;
  logic [WB_AW-1:0] adr;
  logic [BLW-1:0] bl;
  logic [LW-1:0] ptr;
  logic [LNW-1:0] line;
  logic cpu_served;
  logic aborted;
  logic [LW-1:0] cpu_word;
  logic [TAG_WD-1:0] cpu_tag;
  logic [BLW-1:0] pf_bl;
  logic unused_bits;
  assign cpu_word = cpu_addr[LW+1:2];
  assign cpu_tag = cpu_addr[WB_AW-1:LW+2];
  // prefill_lines==0 encodes a full-cache prefill, i.e. the top burst-length bit
  assign pf_bl = {prefill_lines == '0, prefill_lines, {LW{1'b0}}};
  assign unused_bits = ^{cpu_addr[1:0], prefill_base[LW+1:0]};
  assign app.wb_app_stb_o = stb;
  assign app.wb_app_adr_o = adr;
  assign app.wb_app_we_o = 1'b0;
  assign app.wb_app_dat_o = '0;
  assign app.wb_app_sel_o = {4{stb}};
  assign app.wb_app_bl_o = bl;
  assign cache_mem_clk0 = mclk;
  assign cache_mem_wmask0 = {4{~cache_mem_web0}};
  always_ff @(posedge mclk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      stb <= 1'b0;
      adr <= '0;
      bl <= '0;
      ptr <= '0;
      line <= '0;
      cpu_served <= 1'b0;
      aborted <= 1'b0;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
      second <= 1'b0;
`endif
      wb_cpu_dat_o <= '0;
      wb_cpu_ack_o <= 1'b0;
      wb_cpu_err_o <= 1'b0;
      tag_uwr <= 1'b0;
      tag_uptr <= '0;
      tag_wr <= 1'b0;
      tag_wptr <= '0;
      tag_wdata <= '0;
      cache_mem_csb0 <= 1'b1;
      cache_mem_web0 <= 1'b1;
      cache_mem_addr0 <= '0;
      cache_mem_din0 <= '0;
      cache_busy <= 1'b0;
      fill_done <= 1'b0;
      fill_err <= 1'b0;
    end else begin
      wb_cpu_ack_o <= 1'b0;
      wb_cpu_err_o <= 1'b0;
      tag_uwr <= 1'b0;
      tag_wr <= 1'b0;
      cache_mem_csb0 <= 1'b1;
      cache_mem_web0 <= 1'b1;
      fill_done <= 1'b0;
      fill_err <= 1'b0;
      case (state)
        IDLE: begin
          cpu_served <= 1'b0;
          aborted <= 1'b0;
          ptr <= '0;
          cache_busy <= cache_refill_req | cache_prefill_req;
          stb <= cache_refill_req | cache_prefill_req;
          if (cache_refill_req) begin
            line <= tag_cur_loc;
            tag_uwr <= 1'b1;
            tag_uptr <= tag_cur_loc;
            tag_wdata <= '0;
            state <= REFILL;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
            adr <= {cpu_tag, cpu_word, 2'b00};
            bl <= BLW'(CACHESIZE) - BLW'(cpu_word);
            ptr <= cpu_word;
            second <= 1'b0;
`else
            adr <= {cpu_tag, {(LW+2){1'b0}}};
            bl <= BLW'(CACHESIZE);
`endif
          end else if (cache_prefill_req) begin
            line <= '0;
            adr <= {prefill_base[WB_AW-1:LW+2], {(LW+2){1'b0}}};
            bl <= pf_bl;
            state <= PREFILL;
          end
        end
        REFILL, PREFILL: begin
          if (app.wb_app_err_i) begin
            stb <= 1'b0;
            fill_err <= 1'b1;
            aborted <= 1'b1;
            wb_cpu_err_o <= (state == REFILL) && !cpu_served;
            state <= DONE;
          end else begin
            if (app.wb_app_ack_i) begin
              cache_mem_csb0 <= 1'b0;
              cache_mem_web0 <= 1'b0;
              cache_mem_addr0 <= {line, ptr};
              cache_mem_din0 <= app.wb_app_dat_i;
              ptr <= ptr + 1'b1;
              if (state == REFILL && !cpu_served && ptr == cpu_word) begin
                wb_cpu_ack_o <= 1'b1;
                wb_cpu_dat_o <= app.wb_app_dat_i;
                cpu_served <= 1'b1;
              end
              // each completed prefill line becomes valid as soon as its last word lands
              if (state == PREFILL && ptr == '1) begin
                tag_wr <= 1'b1;
                tag_wptr <= line;
                tag_wdata <= {1'b1, adr[WB_AW-1:LW+2] + TAG_WD'(line)};
                line <= line + 1'b1;
              end
            end
            if (app.wb_app_lack_i) begin
              stb <= 1'b0;
              state <= DONE;
              if (state == REFILL) begin
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
                if (!second && cpu_word != '0) state <= REFILL_WRAP;
                else
`endif
                begin
                  tag_wr <= 1'b1;
                  tag_wptr <= line;
                  tag_wdata <= {1'b1, cpu_tag};
                end
              end
            end
          end
        end
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        REFILL_WRAP: begin
          stb <= 1'b1;
          adr <= {cpu_tag, {(LW+2){1'b0}}};
          bl <= BLW'(cpu_word);
          ptr <= '0;
          second <= 1'b1;
          state <= REFILL;
        end
`endif
        DONE: begin
          cache_busy <= 1'b0;
          fill_done <= !aborted;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_icache_line_fill_ctrl.sv
// tb_icache_line_fill_ctrl: randomized bus-slave bench for the I-cache fill controller.
// Observed SRAM/tag/CPU traffic is compared with expectations built from line/word arithmetic.
module tb_icache_line_fill_ctrl;
  localparam int AW = 32, DW = 32, CL = 16, CS = 32;
  localparam int LNW = 4, LW = 5, MAW = LNW + LW, TAG_WD = AW - LW - 2, BLW = MAW + 1;
  logic mclk = 1'b0;
  logic rst_n = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] wb_cpu_dat_o;
  logic wb_cpu_ack_o, wb_cpu_err_o;
  logic [LNW-1:0] tag_cur_loc = '0;
  logic tag_uwr, tag_wr;
  logic [LNW-1:0] tag_uptr, tag_wptr;
  logic [TAG_WD:0] tag_wdata;
  logic cache_mem_clk0, cache_mem_csb0, cache_mem_web0;
  logic [MAW-1:0] cache_mem_addr0;
  logic [3:0] cache_mem_wmask0;
  logic [DW-1:0] cache_mem_din0;
  logic cache_refill_req = 1'b0, cache_prefill_req = 1'b0;
  logic [AW-1:0] prefill_base = '0;
  logic [LNW-1:0] prefill_lines = '0;
  logic cache_busy, fill_done, fill_err;
  icache_line_fill_ctrl_if #(.WB_AW(AW), .WB_DW(DW), .BLW(BLW)) app ();
  icache_line_fill_ctrl #(.WB_AW(AW), .WB_DW(DW), .CACHELINES(CL), .CACHESIZE(CS)) dut (
    .mclk(mclk), .rst_n(rst_n), .cpu_addr(cpu_addr),
    .wb_cpu_dat_o(wb_cpu_dat_o), .wb_cpu_ack_o(wb_cpu_ack_o), .wb_cpu_err_o(wb_cpu_err_o),
    .app(app), .tag_cur_loc(tag_cur_loc),
    .tag_uwr(tag_uwr), .tag_uptr(tag_uptr), .tag_wr(tag_wr), .tag_wptr(tag_wptr), .tag_wdata(tag_wdata),
    .cache_mem_clk0(cache_mem_clk0), .cache_mem_csb0(cache_mem_csb0), .cache_mem_web0(cache_mem_web0),
    .cache_mem_addr0(cache_mem_addr0), .cache_mem_wmask0(cache_mem_wmask0), .cache_mem_din0(cache_mem_din0),
    .cache_refill_req(cache_refill_req), .cache_prefill_req(cache_prefill_req),
    .prefill_base(prefill_base), .prefill_lines(prefill_lines),
    .cache_busy(cache_busy), .fill_done(fill_done), .fill_err(fill_err)
  );
  always #5 mclk = ~mclk;
  int errors = 0, checks = 0;
  int cyc = 0, last_wr = 0, fall = 0, n_done = 0, n_ferr = 0, n_cerr = 0, bad_mask = 0;
  logic busy_d = 1'b0;
  logic [MAW+DW-1:0] wr_q[$];
  logic [LNW+TAG_WD:0] tw_q[$], uw_q[$];
  logic [DW-1:0] ca_q[$], beat_q[$];
  logic [AW-1:0] got_adr;
  logic [BLW-1:0] got_bl;
  initial begin
    app.wb_app_dat_i = '0;
    app.wb_app_ack_i = 1'b0;
    app.wb_app_lack_i = 1'b0;
    app.wb_app_err_i = 1'b0;
  end
  always @(negedge mclk) begin
    cyc++;
    if (!cache_mem_csb0 && !cache_mem_web0) begin
      wr_q.push_back({cache_mem_addr0, cache_mem_din0});
      last_wr = cyc;
      if (cache_mem_wmask0 != 4'hF) bad_mask++;
    end
    if (tag_wr) begin
      tw_q.push_back({tag_wptr, tag_wdata});
      last_wr = cyc;
    end
    if (tag_uwr) uw_q.push_back({tag_uptr, tag_wdata});
    if (wb_cpu_ack_o) ca_q.push_back(wb_cpu_dat_o);
    n_cerr += int'(wb_cpu_err_o);
    n_done += int'(fill_done);
    n_ferr += int'(fill_err);
    if (busy_d && !cache_busy) fall = cyc;
    busy_d = cache_busy;
  end
  task automatic clear_obs();
    wr_q.delete(); tw_q.delete(); uw_q.delete(); ca_q.delete(); beat_q.delete();
    n_done = 0; n_ferr = 0; n_cerr = 0; bad_mask = 0;
  endtask
  task automatic serve(input int err_beat, input int stop_beat, input bit clr_pf);
    bit seen = 0;
    logic [DW-1:0] d;
    for (int i = 0; i < 40; i++) begin
      @(negedge mclk);
      if (app.wb_app_stb_o) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL stb_timeout: stb=0 after 40 cycles, required 1");
      got_bl = '0;
      return;
    end
    cache_refill_req = 1'b0;
    if (clr_pf) cache_prefill_req = 1'b0;
    got_adr = app.wb_app_adr_o;
    got_bl = app.wb_app_bl_o;
    checks++;
    if ({app.wb_app_sel_o, app.wb_app_we_o, app.wb_app_dat_o} !== {4'hF, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL bus_ctl: sel=%h we=%b dat=%h, required F/0/0", app.wb_app_sel_o, app.wb_app_we_o, app.wb_app_dat_o);
    end
    for (int b = 0; b < int'(got_bl); b++) begin
      if (b == stop_beat) return;
      repeat ($urandom_range(0, 2)) @(negedge mclk);
      if (b == err_beat) app.wb_app_err_i = 1'b1;
      else begin
        d = $urandom;
        beat_q.push_back(d);
        app.wb_app_dat_i = d;
        app.wb_app_ack_i = 1'b1;
        app.wb_app_lack_i = (b == int'(got_bl) - 1);
      end
      @(negedge mclk);
      app.wb_app_ack_i = 1'b0;
      app.wb_app_lack_i = 1'b0;
      app.wb_app_err_i = 1'b0;
      if (b == err_beat || b == int'(got_bl) - 1) begin
        checks++;
        if (app.wb_app_stb_o !== 1'b0) begin
          errors++;
          $display("FAIL stb_drop: stb=%b after burst end, required 0", app.wb_app_stb_o);
        end
        return;
      end
    end
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 50 && cache_busy; i++) @(negedge mclk);
    checks++;
    if (cache_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_timeout: busy=%b, required 0", cache_busy);
    end
    #1;
  endtask
  task automatic do_refill(input logic [AW-1:0] addr, input int loc, input int err_beat);
    int w, nw, pos, bad;
    int ord[$];
    bit served;
    logic [TAG_WD-1:0] tg;
    w = int'(addr[LW+1:2]);
    tg = addr[AW-1:LW+2];
    clear_obs();
    cpu_addr = addr;
    tag_cur_loc = loc[LNW-1:0];
    cache_refill_req = 1'b1;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    for (int i = 0; i < CS; i++) ord.push_back((w + i) % CS);
    pos = 0;
    serve(err_beat, -1, 0);
    checks++;
    if (got_adr !== {tg, w[LW-1:0], 2'b00} || got_bl !== BLW'(CS - w)) begin
      errors++;
      $display("FAIL cwf_burst1: adr=%h bl=%0d, required %h/%0d", got_adr, got_bl, {tg, w[LW-1:0], 2'b00}, CS - w);
    end
    if (w != 0 && (err_beat < 0 || err_beat >= CS - w)) begin
      serve(err_beat < 0 ? -1 : err_beat - (CS - w), -1, 0);
      checks++;
      if (got_adr !== {tg, 7'h0} || got_bl !== BLW'(w)) begin
        errors++;
        $display("FAIL cwf_burst2: adr=%h bl=%0d, required %h/%0d", got_adr, got_bl, {tg, 7'h0}, w);
      end
    end
`else
    for (int i = 0; i < CS; i++) ord.push_back(i);
    pos = w;
    serve(err_beat, -1, 0);
    checks++;
    if (got_adr !== {tg, 7'h0} || got_bl !== BLW'(CS)) begin
      errors++;
      $display("FAIL refill_burst: adr=%h bl=%0d, required %h/%0d", got_adr, got_bl, {tg, 7'h0}, CS);
    end
`endif
    wait_idle();
    nw = err_beat < 0 ? CS : err_beat;
    served = err_beat < 0 || pos < err_beat;
    bad = 0;
    for (int k = 0; k < nw && k < wr_q.size() && k < beat_q.size(); k++)
      if (wr_q[k] !== {MAW'(loc * CS + ord[k]), beat_q[k]}) bad++;
    checks++;
    if (wr_q.size() != nw || bad != 0 || bad_mask != 0) begin
      errors++;
      $display("FAIL refill_sram: writes=%0d wrong=%0d badmask=%0d, required %0d/0/0", wr_q.size(), bad, bad_mask, nw);
    end
    checks++;
    if (uw_q.size() != 1 || uw_q[0] !== {loc[LNW-1:0], {(TAG_WD+1){1'b0}}}) begin
      errors++;
      $display("FAIL tag_inval: count=%0d first=%h, required 1 at loc %0d data 0", uw_q.size(), uw_q.size() ? uw_q[0] : '0, loc);
    end
    checks++;
    if (ca_q.size() != int'(served) || (served && pos < beat_q.size() && ca_q[0] !== beat_q[pos])) begin
      errors++;
      $display("FAIL cpu_ack: acks=%0d data=%h, required %0d data %h", ca_q.size(), ca_q.size() ? ca_q[0] : '0, served,
               pos < beat_q.size() ? beat_q[pos] : '0);
    end
    checks++;
    if (n_cerr != int'(!served)) begin
      errors++;
      $display("FAIL cpu_err: pulses=%0d, required %0d", n_cerr, !served);
    end
    checks++;
    if (err_beat >= 0 ? tw_q.size() != 0 : (tw_q.size() != 1 || tw_q[0] !== {loc[LNW-1:0], 1'b1, tg})) begin
      errors++;
      $display("FAIL refill_tag: count=%0d first=%h, required %0d %h", tw_q.size(), tw_q.size() ? tw_q[0] : '0,
               err_beat < 0, {loc[LNW-1:0], 1'b1, tg});
    end
    checks++;
    if (n_done != int'(err_beat < 0) || n_ferr != int'(err_beat >= 0)) begin
      errors++;
      $display("FAIL refill_status: done=%0d err=%0d, required %0d/%0d", n_done, n_ferr, err_beat < 0, err_beat >= 0);
    end
    if (err_beat < 0) begin
      checks++;
      if (fall - last_wr != 1) begin
        errors++;
        $display("FAIL busy_fall: busy dropped %0d cycles after last write, required 1", fall - last_wr);
      end
    end
  endtask
  task automatic do_prefill(input logic [AW-1:0] base, input int lines, input int err_beat);
    int n, nw, ntag, bad;
    logic [TAG_WD-1:0] tb;
    n = lines == 0 ? CL : lines;
    tb = base[AW-1:LW+2];
    clear_obs();
    prefill_base = base;
    prefill_lines = lines[LNW-1:0];
    cache_prefill_req = 1'b1;
    serve(err_beat, -1, 1);
    checks++;
    if (got_adr !== {tb, 7'h0} || got_bl !== BLW'(n * CS)) begin
      errors++;
      $display("FAIL prefill_burst: adr=%h bl=%0d, required %h/%0d", got_adr, got_bl, {tb, 7'h0}, n * CS);
    end
    wait_idle();
    nw = err_beat < 0 ? n * CS : err_beat;
    ntag = nw / CS;
    bad = 0;
    for (int k = 0; k < nw && k < wr_q.size() && k < beat_q.size(); k++)
      if (wr_q[k] !== {MAW'(k), beat_q[k]}) bad++;
    checks++;
    if (wr_q.size() != nw || bad != 0 || bad_mask != 0) begin
      errors++;
      $display("FAIL prefill_sram: writes=%0d wrong=%0d badmask=%0d, required %0d/0/0", wr_q.size(), bad, bad_mask, nw);
    end
    bad = 0;
    for (int k = 0; k < ntag && k < tw_q.size(); k++)
      if (tw_q[k] !== {LNW'(k), 1'b1, tb + TAG_WD'(k)}) bad++;
    checks++;
    if (tw_q.size() != ntag || bad != 0) begin
      errors++;
      $display("FAIL prefill_tag: count=%0d wrong=%0d, required %0d/0", tw_q.size(), bad, ntag);
    end
    checks++;
    if (n_done != int'(err_beat < 0) || n_ferr != int'(err_beat >= 0) || uw_q.size() != 0 || ca_q.size() != 0 || n_cerr != 0) begin
      errors++;
      $display("FAIL prefill_status: done=%0d err=%0d inval=%0d cpuack=%0d cpuerr=%0d, required %0d/%0d/0/0/0",
               n_done, n_ferr, uw_q.size(), ca_q.size(), n_cerr, err_beat < 0, err_beat >= 0);
    end
    if (err_beat < 0) begin
      checks++;
      if (fall - last_wr != 1) begin
        errors++;
        $display("FAIL busy_fall: busy dropped %0d cycles after last write, required 1", fall - last_wr);
      end
    end
  endtask
  task automatic check_reset_state(input string tag);
    checks++;
    if ({cache_busy, app.wb_app_stb_o, cache_mem_csb0, cache_mem_web0, tag_uwr, tag_wr, fill_done, fill_err,
         wb_cpu_ack_o, wb_cpu_err_o} !== 10'b0011000000) begin
      errors++;
      $display("FAIL %s_ctl: busy/stb/csb/web/uwr/wr/done/err/ack/cerr=%b, required 0011000000", tag,
               {cache_busy, app.wb_app_stb_o, cache_mem_csb0, cache_mem_web0, tag_uwr, tag_wr, fill_done, fill_err,
                wb_cpu_ack_o, wb_cpu_err_o});
    end
    checks++;
    if (app.wb_app_adr_o !== '0 || app.wb_app_bl_o !== '0 || app.wb_app_sel_o !== 4'h0 || cache_mem_addr0 !== '0 ||
        cache_mem_din0 !== '0 || tag_wdata !== '0 || wb_cpu_dat_o !== '0 || cache_mem_wmask0 !== 4'h0) begin
      errors++;
      $display("FAIL %s_data: adr=%h bl=%0d sel=%h addr0=%h din0=%h tagd=%h cpud=%h, required all 0", tag,
               app.wb_app_adr_o, app.wb_app_bl_o, app.wb_app_sel_o, cache_mem_addr0, cache_mem_din0, tag_wdata, wb_cpu_dat_o);
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge mclk);
    check_reset_state("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge mclk);
    checks++;
    if (cache_busy !== 1'b0 || app.wb_app_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet: busy=%b stb=%b with no request, required 0/0", cache_busy, app.wb_app_stb_o);
    end
  endtask
  task automatic test_refill();
    do_refill(32'h0000_1A54, 3, -1);
    do_refill({$urandom} & 32'hFFFF_FF80, $urandom_range(0, CL - 1), -1);
    do_refill({$urandom} | 32'h0000_007C, $urandom_range(0, CL - 1), -1);
    repeat (2) do_refill($urandom, $urandom_range(0, CL - 1), -1);
  endtask
  task automatic test_prefill();
    do_prefill(32'h0000_0800, 0, -1);
    do_prefill($urandom, $urandom_range(1, 3), -1);
    do_prefill($urandom, 2, 40);
  endtask
  task automatic test_error();
    do_refill(32'h0000_1A28, 5, 4);
    do_refill($urandom, $urandom_range(0, CL - 1), 0);
    do_refill($urandom, $urandom_range(0, CL - 1), $urandom_range(1, CS - 1));
  endtask
  task automatic test_priority();
    prefill_base = 32'h0000_4000;
    prefill_lines = 4'd1;
    cache_prefill_req = 1'b1;
    do_refill($urandom, $urandom_range(0, CL - 1), -1);
    do_prefill(32'h0000_4000, 1, -1);
  endtask
  task automatic test_reset_mid();
    clear_obs();
    prefill_base = 32'h0000_0800;
    prefill_lines = '0;
    cache_prefill_req = 1'b1;
    serve(-1, 40, 1);
    rst_n = 1'b0;
    #1;
    check_reset_state("reset_mid");
    repeat (2) @(negedge mclk);
    rst_n = 1'b1;
    @(negedge mclk);
    do_refill($urandom, $urandom_range(0, CL - 1), -1);
  endtask
  initial begin
    test_reset();
    test_refill();
    test_prefill();
    test_error();
    test_priority();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
